inv_sbox_builder: RTL and testbench

- Consumer of the finished forward S-box: once S-box generation has completed, scans the 256-entry forward table, checks it is a bijection, and writes the inverse table (inv[sbox[i]] = i) used by the decryption datapath.
- Sits between the forward S-box RAM (read port) and the inverse S-box RAM (write port).
- Started by a pulse after the S-box generator signals completion.

---
 rtl/inv_sbox_builder.sv | 128 ++++++++++++
 tb/tb_inv_sbox_builder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sbox_builder.sv
`default_nettype none
// ============================================================================
// Module   : inv_sbox_builder
// Purpose  : Scans the finished forward S-box, checks it is a bijection and
//            writes the inverse table (inv[sbox[i]] = i).
//            Optional macro INV_SBOX_ABORT_EN stops the scan on the first
//            duplicate value.
// Revision : 1.0 - initial release
// ============================================================================
module inv_sbox_builder #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              sbox_rd_en_o,
    output logic [DATA_W-1:0] sbox_rd_addr_o,
    input  logic [DATA_W-1:0] sbox_rd_data_i,
    output logic              inv_wr_en_o,
    output logic [DATA_W-1:0] inv_wr_addr_o,
    output logic [DATA_W-1:0] inv_wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [DATA_W-1:0] dup_value_o
);

    localparam int DEPTH = 2**DATA_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [DATA_W:0]   cnt_q;
    logic [DATA_W:0]   cnt_d;
    logic              rd_vld_q;
    logic [DATA_W-1:0] rd_idx_q;
    logic [DEPTH-1:0]  seen_q;
    logic              dup_d;
    logic              wr_d;

    // Extra counter bit flags the terminal index without wrapping the address
    assign cnt_d          = cnt_q + {{DATA_W{1'b0}}, 1'b1};
    assign sbox_rd_addr_o = cnt_q[DATA_W-1:0];

    always_comb begin
        dup_d = rd_vld_q && seen_q[sbox_rd_data_i];
`ifdef INV_SBOX_ABORT_EN
        wr_d  = rd_vld_q && !seen_q[sbox_rd_data_i] && !error_o;
`else
        wr_d  = rd_vld_q && !seen_q[sbox_rd_data_i];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rd_vld_q      <= 1'b0;
            rd_idx_q      <= '0;
            seen_q        <= '0;
            sbox_rd_en_o  <= 1'b0;
            inv_wr_en_o   <= 1'b0;
            inv_wr_addr_o <= '0;
            inv_wr_data_o <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
            dup_value_o   <= '0;
        end else begin
            rd_vld_q    <= sbox_rd_en_o;
            rd_idx_q    <= cnt_q[DATA_W-1:0];
            inv_wr_en_o <= wr_d;
            if (wr_d) begin
                seen_q[sbox_rd_data_i] <= 1'b1;
                inv_wr_addr_o          <= sbox_rd_data_i;
                inv_wr_data_o          <= rd_idx_q;
            end
            if (dup_d && !error_o) begin
                error_o     <= 1'b1;
                dup_value_o <= sbox_rd_data_i;
            end

            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q      <= S_READ;
                        cnt_q        <= '0;
                        seen_q       <= '0;
                        error_o      <= 1'b0;
                        dup_value_o  <= '0;
                        sbox_rd_en_o <= 1'b1;
                        busy_o       <= 1'b1;
                        done_o       <= 1'b0;
                    end
                end
                S_READ: begin
                    cnt_q <= cnt_d;
                    if (cnt_d[DATA_W]) begin
                        state_q      <= S_DRAIN;
                        sbox_rd_en_o <= 1'b0;
                    end
`ifdef INV_SBOX_ABORT_EN
                    if (dup_d && !error_o) begin
                        state_q      <= S_DRAIN;
                        sbox_rd_en_o <= 1'b0;
                    end
`endif
                end
                S_DRAIN: begin
                    // Last read data is consumed in the cycle rd_vld_q is high
                    if (!rd_vld_q) begin
                        state_q <= S_DONE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inv_sbox_builder.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_sbox_builder
// Purpose  : Self-checking bench for inv_sbox_builder with a table-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_sbox_builder;

`ifdef INV_SBOX_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_i = 1'b0;
    logic       sbox_rd_en_o;
    logic [7:0] sbox_rd_addr_o;
    logic [7:0] sbox_rd_data_i = 8'h00;
    logic       inv_wr_en_o;
    logic [7:0] inv_wr_addr_o;
    logic [7:0] inv_wr_data_o;
    logic       busy_o;
    logic       done_o;
    logic       error_o;
    logic [7:0] dup_value_o;

    inv_sbox_builder #(.DATA_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .sbox_rd_en_o   (sbox_rd_en_o),
        .sbox_rd_addr_o (sbox_rd_addr_o),
        .sbox_rd_data_i (sbox_rd_data_i),
        .inv_wr_en_o    (inv_wr_en_o),
        .inv_wr_addr_o  (inv_wr_addr_o),
        .inv_wr_data_o  (inv_wr_data_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .dup_value_o    (dup_value_o)
    );

    always #5 clk = ~clk;

    logic [7:0] sbox_mem [256];
    logic [7:0] inv_mem  [256];
    int         cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sbox_rd_en_o) sbox_rd_data_i <= sbox_mem[sbox_rd_addr_o];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Expected behaviour of one run, relative to the start-sampling cycle t0
    int         t0 = 0;
    bit         mdl_en = 1'b0;
    int         exp_last_rd, exp_done_k, exp_dup_i;
    logic [7:0] exp_dup_val;
    bit         exp_wr_en   [260];
    logic [7:0] exp_wr_addr [260];
    logic [7:0] exp_wr_data [260];

    task automatic build_model();
        bit seen [256];
        int d;
        d = -1;
        exp_dup_val = 8'h00;
        for (int k = 0; k < 260; k++) exp_wr_en[k] = 1'b0;
        for (int v = 0; v < 256; v++) seen[v] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (seen[sbox_mem[i]]) begin
                if (d < 0) begin
                    d = i;
                    exp_dup_val = sbox_mem[i];
                end
            end else begin
                seen[sbox_mem[i]] = 1'b1;
                if (!(ABORT && d >= 0)) begin
                    exp_wr_en[3+i]   = 1'b1;
                    exp_wr_addr[3+i] = sbox_mem[i];
                    exp_wr_data[3+i] = 8'(i);
                end
            end
        end
        exp_dup_i   = d;
        exp_last_rd = 256;
        exp_done_k  = 259;
        if (ABORT && d >= 0) begin
            if (2 + d < exp_last_rd) exp_last_rd = 2 + d;
            if (5 + d < exp_done_k)  exp_done_k  = 5 + d;
        end
    endtask

    // Per-run observations
    int wr_cnt, first_wr_k, last_wr_k, busy_cnt, done_rise_k;
    bit wr_at13;
    int mk;
    bit e_rd, e_wr, e_err;

    always @(negedge clk) begin
        if (mdl_en && rst) begin
            mk = cyc - t0;
            if (mk >= 1) begin
                e_rd = (mk <= exp_last_rd);
                check("rd_en", 32'(sbox_rd_en_o), 32'(e_rd));
                if (e_rd) check("rd_addr", 32'(sbox_rd_addr_o), 32'(mk - 1));
                e_wr = (mk < 260) ? exp_wr_en[mk] : 1'b0;
                check("wr_en", 32'(inv_wr_en_o), 32'(e_wr));
                if (e_wr) begin
                    check("wr_addr", 32'(inv_wr_addr_o), 32'(exp_wr_addr[mk]));
                    check("wr_data", 32'(inv_wr_data_o), 32'(exp_wr_data[mk]));
                end
                check("busy", 32'(busy_o), 32'(mk < exp_done_k));
                check("done", 32'(done_o), 32'(mk >= exp_done_k));
                e_err = (exp_dup_i >= 0) && (mk >= exp_dup_i + 3);
                check("error", 32'(error_o), 32'(e_err));
                check("dup_value", 32'(dup_value_o), e_err ? 32'(exp_dup_val) : 32'd0);

                if (inv_wr_en_o) begin
                    wr_cnt++;
                    if (first_wr_k < 0) first_wr_k = mk;
                    last_wr_k = mk;
                    inv_mem[inv_wr_addr_o] = inv_wr_data_o;
                    if (mk == 13) wr_at13 = 1'b1;
                end
                if (busy_o) busy_cnt++;
                if (done_o && done_rise_k < 0) done_rise_k = mk;
            end
        end
    end

    task automatic start_run();
        @(negedge clk);
        #1;
        build_model();
        wr_cnt = 0; first_wr_k = -1; last_wr_k = -1;
        busy_cnt = 0; done_rise_k = -1; wr_at13 = 1'b0;
        for (int v = 0; v < 256; v++) inv_mem[v] = 8'hxx;
        t0      = cyc;
        mdl_en  = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic finish_run();
        while (cyc < t0 + exp_done_k + 2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},   32'(sbox_rd_en_o),   32'd0);
        check({tag, "_rd_addr"}, 32'(sbox_rd_addr_o), 32'd0);
        check({tag, "_wr_en"},   32'(inv_wr_en_o),    32'd0);
        check({tag, "_busy"},    32'(busy_o),         32'd0);
        check({tag, "_done"},    32'(done_o),         32'd0);
        check({tag, "_error"},   32'(error_o),        32'd0);
        check({tag, "_dup"},     32'(dup_value_o),    32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sbox_mem[i] = 8'(i);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #1 rst = 1'b1;

        // Identity table
        start_run();
        finish_run();
        check("id_wr_cnt",   32'(wr_cnt),      32'd256);
        check("id_first_wr", 32'(first_wr_k),  32'd3);
        check("id_last_wr",  32'(last_wr_k),   32'd258);
        check("id_done_at",  32'(done_rise_k), 32'd259);
        check("id_error",    32'(error_o),     32'd0);
        check("id_inv_7f",   32'(inv_mem[8'h7F]), 32'h7F);

        // XOR table
        for (int i = 0; i < 256; i++) sbox_mem[i] = 8'(i) ^ 8'hA5;
        start_run();
        finish_run();
        for (int i = 0; i < 256; i++) check("xor_inv", 32'(inv_mem[i]), 32'(8'(i) ^ 8'hA5));
        check("xor_inv_00", 32'(inv_mem[8'h00]), 32'hA5);
        check("xor_busy",   32'(busy_cnt),       32'd258);
        check("xor_error",  32'(error_o),        32'd0);

        // Duplicate: identity except sbox[10] = 0x03
        for (int i = 0; i < 256; i++) sbox_mem[i] = 8'(i);
        sbox_mem[10] = 8'h03;
        start_run();
        finish_run();
        check("dup_error", 32'(error_o),     32'd1);
        check("dup_value", 32'(dup_value_o), 32'h03);
        check("dup_wr13",  32'(wr_at13),     32'd0);
        if (ABORT) begin
            check("dup_wr_cnt",  32'(wr_cnt),      32'd10);
            check("dup_last_wr", 32'(last_wr_k),   32'd12);
            check("dup_done_at", 32'(done_rise_k), 32'd15);
        end else begin
            check("dup_wr_cnt",  32'(wr_cnt),      32'd255);
            check("dup_done_at", 32'(done_rise_k), 32'd259);
        end

        // start pulsed mid-run is ignored
        sbox_mem[10] = 8'h0A;
        start_run();
        while (cyc < t0 + 50) @(negedge clk);
        #1 start_i = 1'b1;
        @(negedge clk);
        #1 start_i = 1'b0;
        finish_run();
        check("ign_wr_cnt",  32'(wr_cnt),      32'd256);
        check("ign_done_at", 32'(done_rise_k), 32'd259);

        // Reset mid-run on a duplicate table, then a fresh identity build
        sbox_mem[10] = 8'h03;
        start_run();
        while (cyc < t0 + 100) @(negedge clk);
        #1;
        rst    = 1'b0;
        mdl_en = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        #1 rst = 1'b1;
        sbox_mem[10] = 8'h0A;
        while (cyc < t0 + 104) @(negedge clk);
        start_run();
        finish_run();
        check("rst_wr_cnt",  32'(wr_cnt),      32'd256);
        check("rst_done_at", 32'(done_rise_k), 32'd259);
        check("rst_error",   32'(error_o),     32'd0);
        check("rst_dup",     32'(dup_value_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
